// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller and its slave-side bench models.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

    // Mode encoding is {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response signals plus the four SPI pins of one master.
interface spi_master_ctrl_if #(parameter int DATA_W = 8);

    logic              start;
    logic              cpol;
    logic              cpha;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              cs;
    logic              sclk;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, cpol, cpha, tx_data, miso,
        output rx_data, busy, done, cs, sclk, mosi
    );

    modport slave (
        output start, cpol, cpha, tx_data, miso,
        input  rx_data, busy, done, cs, sclk, mosi
    );

endinterface

// File: rtl/spi_clk_gen.sv
// SPI clock divider: toggles sclk every CLK_DIV cycles for exactly 2*DATA_W edges
// and flags each edge (leading/trailing/last) with a strobe that lines up with the new sclk level.
module spi_clk_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic idle_level,
    output logic sclk,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_edge
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            edge_cnt  <= '0;
            sclk      <= 1'b0;
            lead_stb  <= 1'b0;
            trail_stb <= 1'b0;
            last_edge <= 1'b0;
        end else begin
            lead_stb  <= 1'b0;
            trail_stb <= 1'b0;
            last_edge <= 1'b0;
            if (!en) begin
                div_cnt  <= '0;
                edge_cnt <= '0;
                sclk     <= idle_level;
            end else if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                // Edge count saturates so a lingering enable never adds a stray edge
                if (edge_cnt <= EDGE_LAST) begin
                    sclk      <= ~sclk;
                    edge_cnt  <= edge_cnt + 1'b1;
                    lead_stb  <= ~edge_cnt[0];
                    trail_stb <= edge_cnt[0];
                    last_edge <= (edge_cnt == EDGE_LAST);
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: accepts one start/tx_data request, runs a full-duplex DATA_W-bit frame
// in any cpol/cpha mode and returns rx_data with a one-cycle done pulse.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(max2(CS_SETUP, CS_HOLD) + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              cpol_l;
    logic              cpha_l;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              lead_stb;
    logic              trail_stb;
    logic              last_edge;
    logic              sample_stb;
    logic              shift_stb;

    assign sample_stb = cpha_l ? trail_stb : lead_stb;
    assign shift_stb  = cpha_l ? lead_stb  : (trail_stb & ~last_edge);

    spi_clk_gen #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state == XFER),
        .idle_level ((state == IDLE) ? bus.cpol : cpol_l),
        .sclk       (bus.sclk),
        .lead_stb   (lead_stb),
        .trail_stb  (trail_stb),
        .last_edge  (last_edge)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            bus.rx_data <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.cs      <= 1'b1;
            bus.mosi    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (sample_stb) rx_sh <= {rx_sh[DATA_W-2:0], bus.miso};
            // tx_sh[MSB] always holds the next bit to put on mosi
            if (shift_stb) begin
                bus.mosi <= tx_sh[DATA_W-1];
                tx_sh    <= tx_sh << 1;
            end
            case (state)
                IDLE: begin
                    bus.cs <= 1'b1;
                    if (bus.start) begin
                        cpol_l   <= bus.cpol;
                        cpha_l   <= bus.cpha;
                        tx_sh    <= bus.cpha ? bus.tx_data : (bus.tx_data << 1);
                        bus.mosi <= bus.tx_data[DATA_W-1];
                        bus.cs   <= 1'b0;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (last_edge) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt         <= '0;
                        bus.cs      <= 1'b1;
                        bus.rx_data <= rx_sh;
                        bus.done    <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench: a behavioural SPI slave on instance A, back-to-back timing on instance B.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int LAT_A = 1 + 2 + 2 * 8 * 4 + 2 + 1;
    localparam int LAT_B = 1 + 1 + 2 * 8 * 2 + 1 + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_ctrl_if #(.DATA_W(8)) bus_a ();
    spi_master_ctrl_if #(.DATA_W(8)) bus_b ();

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_b.miso = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Behavioural slave on bus A: shifts s_tx out MSB first and captures mosi
    logic [1:0] s_mode;
    logic [7:0] s_tx, s_rx, s_read;
    int         s_idx, s_lead, s_trail, s_lead_f, s_trail_f;
    logic       p_cs = 1'b1;
    logic       p_sclk = 1'b0;

    always @(bus_a.cs, bus_a.sclk) begin
        if (p_cs && !bus_a.cs) begin
            s_rx = '0; s_lead = 0; s_trail = 0; s_idx = 7;
            if (!s_mode[0]) begin
                bus_a.miso = s_tx[7];
                s_idx = 6;
            end
        end else if (!p_cs && bus_a.cs) begin
            s_read = s_rx; s_lead_f = s_lead; s_trail_f = s_trail;
        end else if (!bus_a.cs && bus_a.sclk != p_sclk) begin
            if (bus_a.sclk != s_mode[1]) begin
                s_lead++;
                if (s_mode[0]) begin
                    bus_a.miso = (s_idx >= 0) ? s_tx[s_idx] : 1'b0;
                    s_idx--;
                end else s_rx = {s_rx[6:0], bus_a.mosi};
            end else begin
                s_trail++;
                if (!s_mode[0]) begin
                    bus_a.miso = (s_idx >= 0) ? s_tx[s_idx] : 1'b0;
                    s_idx--;
                end else s_rx = {s_rx[6:0], bus_a.mosi};
            end
        end
        p_cs = bus_a.cs;
        p_sclk = bus_a.sclk;
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         done_cyc;
        logic       cpol;
    } exp_t;
    exp_t exp_q[$];

    // Monitor A: every done pops one expected frame
    always @(negedge clk) begin
        if (rst_n && bus_a.done) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_data", bus_a.rx_data, e.rx);
                check("slave_read", s_read, e.tx);
                check("done_cycle", cyc, e.done_cyc);
                check("lead_edges", s_lead_f, 8);
                check("trail_edges", s_trail_f, 8);
                check("cs_high_at_done", bus_a.cs, 1'b1);
                check("sclk_idle", bus_a.sclk, e.cpol);
            end
        end
    end

    // Monitor B: latency, frame period and cs-high gap under a held start
    int b_start = -1;
    int b_prev = -1;
    int b_dones = 0;
    int b_high = 0;
    bit b_armed = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_b.cs) b_high++;
            else begin
                if (b_armed && b_high != 0) check("b_cs_gap", b_high, 2);
                b_high = 0;
            end
            if (bus_b.done) begin
                if (b_prev < 0) check("b_latency", cyc - b_start, LAT_B);
                else check("b_period", cyc - b_prev, LAT_B + 1);
                check("b_rx_data", bus_b.rx_data, 8'hFF);
                b_prev = cyc;
                b_dones++;
                b_armed = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((bus_a.busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("wait_idle");
    endtask

    task automatic run_frame(input logic [1:0] mode, input logic [7:0] tx, input logic [7:0] sv,
                             input bit expect_done);
        wait_idle();
        bus_a.cpol = mode[1];
        bus_a.cpha = mode[0];
        s_mode = mode;
        s_tx = sv;
        repeat (2) @(negedge clk);
        if (expect_done) exp_q.push_back('{tx: tx, rx: sv, done_cyc: cyc + LAT_A, cpol: mode[1]});
        bus_a.tx_data = tx;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        check("busy_after_accept", bus_a.busy, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus_a.start = 1'b0; bus_a.cpol = 1'b0; bus_a.cpha = 1'b0; bus_a.tx_data = '0;
        bus_b.start = 1'b0; bus_b.cpol = 1'b0; bus_b.cpha = 1'b0; bus_b.tx_data = 8'hA5;
        s_mode = MODE0; s_tx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", bus_a.cs, 1'b1);
        check("rst_sclk", bus_a.sclk, 1'b0);
        check("rst_mosi", bus_a.mosi, 1'b0);
        check("rst_busy", bus_a.busy, 1'b0);
        check("rst_done", bus_a.done, 1'b0);
        check("rst_rx_data", bus_a.rx_data, 8'h00);
        rst_n = 1'b1;

        // All four modes with the reference pattern
        run_frame(MODE0, 8'hCA, 8'h3C, 1'b1);
        run_frame(MODE1, 8'hCA, 8'h3C, 1'b1);
        run_frame(MODE2, 8'hCA, 8'h3C, 1'b1);
        run_frame(MODE3, 8'hCA, 8'h3C, 1'b1);

        // Second start while busy must be dropped
        run_frame(MODE0, 8'hCA, 8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        bus_a.tx_data = 8'hFF;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);

        // Reset around bit 4 aborts the frame without a done
        run_frame(MODE1, 8'h5A, 8'h96, 1'b0);
        repeat (33) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_cs", bus_a.cs, 1'b1);
        check("abort_sclk", bus_a.sclk, 1'b0);
        check("abort_busy", bus_a.busy, 1'b0);
        check("abort_rx_data", bus_a.rx_data, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(MODE1, 8'h5A, 8'h96, 1'b1);

        for (int i = 0; i < 8; i++)
            run_frame(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b1);
        wait_idle();

        // Back-to-back frames on the fast instance
        b_start = cyc;
        bus_b.start = 1'b1;
        begin
            int n = 0;
            while (b_dones < 4 && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (n >= 400) fail_now("b_frames");
        end
        bus_b.start = 1'b0;
        repeat (50) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
